// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from the TX FIFO and shifts them out LSB-first as
// start / 8 data / optional parity / stop frames, each bit lasting a latched baud period.
module uart_tx_serializer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 fifo_empty,
  input  logic [7:0]           fifo_rdata,
  output logic                 fifo_renable,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 tx_out,
  output logic                 tx_busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               state, state_n;
  logic [7:0]           shift, shift_n;
  logic [DIV_WIDTH-1:0] period, period_n, cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic                 par_en, par_en_n, par_bit, par_bit_n, tx_n, last, pop;
  assign last = cnt == period - DIV_WIDTH'(1);
  assign pop = !fifo_empty && (state == IDLE || (state == STOP && last));
  assign fifo_renable = pop;
  assign tx_busy = state != IDLE || pop;
  always_comb begin
    state_n = state;
    shift_n = shift;
    period_n = period;
    idx_n = idx;
    par_en_n = par_en;
    par_bit_n = par_bit;
    cnt_n = (last || state == IDLE) ? '0 : cnt + DIV_WIDTH'(1);
    if (pop) begin
      state_n = START;
      shift_n = fifo_rdata;
      period_n = baud_div == '0 ? DIV_WIDTH'(1) : baud_div;
      par_en_n = parity_en;
      par_bit_n = ^fifo_rdata ^ parity_odd;
      cnt_n = '0;
    end else if (last) begin
      case (state)
        START: begin
          state_n = DATA;
          idx_n = '0;
        end
        DATA: begin
          state_n = idx == 3'd7 ? (par_en ? PARITY : STOP) : DATA;
          idx_n = idx + 3'd1;
          shift_n = shift >> 1;
        end
        PARITY: state_n = STOP;
        STOP: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
    // tx_out is registered from the next state so the line changes on the same edge as the state
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par_bit_n : 1'b1;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      shift <= '0;
      period <= '0;
      cnt <= '0;
      idx <= '0;
      par_en <= 1'b0;
      par_bit <= 1'b0;
      tx_out <= 1'b1;
    end else begin
      state <= state_n;
      shift <= shift_n;
      period <= period_n;
      cnt <= cnt_n;
      idx <= idx_n;
      par_en <= par_en_n;
      par_bit <= par_bit_n;
      tx_out <= tx_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: FIFO/line model that predicts every cycle of tx_out, tx_busy and
// fifo_renable, plus literal frame pins for the directed scenarios and a random phase.
module tb_uart_tx_serializer;
  localparam int HN = 8192;
  logic        tb_clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_rdata = 8'h00;
  logic        fifo_renable;
  logic [15:0] baud_div = 16'd4;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        tx_out, tx_busy;
  int          n_checks = 0, n_fail = 0, cyc = 0;
  logic [7:0]  fifo_q[$];
  logic        line[$];
  logic        fb[$];
  int          pop_at[$];
  logic        tx_hist[HN];
  logic        bsy_hist[HN];
  bit          pop_req = 0;

  uart_tx_serializer #(.DIV_WIDTH(16)) dut (
    .clk(tb_clk), .n_rst(n_rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_renable(fifo_renable), .baud_div(baud_div), .parity_en(parity_en),
    .parity_odd(parity_odd), .tx_out(tx_out), .tx_busy(tx_busy)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic chk(string n, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Reference: the line is a queue of future tx levels; a pop appends a whole frame.
  logic exp_tx, exp_busy, mpop;
  int   mp;
  always begin
    @(negedge tb_clk);
    if (cyc < HN) begin
      tx_hist[cyc] = tx_out;
      bsy_hist[cyc] = tx_busy;
    end
    if (fifo_renable === 1'b1) pop_at.push_back(cyc);
    if (!n_rst) begin
      line.delete();
      mpop = 1'b0;
      exp_tx = 1'b1;
      exp_busy = 1'b0;
    end else begin
      mpop = fifo_q.size() != 0 && line.size() <= 1;
      exp_tx = line.size() != 0 ? line[0] : 1'b1;
      exp_busy = line.size() != 0 || mpop;
    end
    chk("tx_out", int'(tx_out), int'(exp_tx));
    chk("tx_busy", int'(tx_busy), int'(exp_busy));
    chk("fifo_renable", int'(fifo_renable), int'(mpop));
    if (line.size() != 0) void'(line.pop_front());
    if (mpop) begin
      mp = baud_div == 0 ? 1 : int'(baud_div);
      fb.delete();
      fb.push_back(1'b0);
      for (int i = 0; i < 8; i++) fb.push_back(fifo_q[0][i]);
      if (parity_en) fb.push_back((^fifo_q[0]) ^ parity_odd);
      fb.push_back(1'b1);
      foreach (fb[i]) repeat (mp) line.push_back(fb[i]);
    end
    pop_req = mpop;
    cyc++;
  end

  function automatic void refresh();
    fifo_empty = fifo_q.size() == 0;
    fifo_rdata = fifo_empty ? 8'h00 : fifo_q[0];
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge tb_clk);
      #1;
      if (pop_req) begin
        void'(fifo_q.pop_front());
        pop_req = 0;
      end
      refresh();
    end
  endtask

  task automatic push(logic [7:0] b);
    fifo_q.push_back(b);
    refresh();
  endtask

  function automatic int pop_cycle(int k);
    return k < pop_at.size() ? pop_at[k] : -1;
  endfunction

  task automatic frame_chk(string n, int c, int p, int nb, logic [10:0] bits);
    int bad;
    bad = -1;
    n_checks++;
    if (c < 0 || c + nb * p + 1 >= HN) begin
      n_fail++;
      $display("FAIL %s: frame start cycle %0d, expected a pop", n, c);
      return;
    end
    for (int i = 0; i < nb * p; i++)
      if (bad < 0 && tx_hist[c + 1 + i] !== bits[i / p]) bad = i;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: tx at frame clock %0d is %b, expected %b", n, bad, tx_hist[c + 1 + bad], bits[bad / p]);
    end
  endtask

  function automatic int busy_len(int c);
    int k;
    k = 0;
    if (c < 0) return -1;
    while (c + k < HN && bsy_hist[c + k] === 1'b1) k++;
    return k;
  endfunction

  int base;
  initial begin
    #1 n_rst = 1'b0;
    #1;
    chk("reset_tx", int'(tx_out), 1);
    chk("reset_busy", int'(tx_busy), 0);
    chk("reset_ren", int'(fifo_renable), 0);
    tick(3);
    n_rst = 1'b1;
    tick(100);
    chk("idle_pops", pop_at.size(), 0);

    base = pop_at.size();
    baud_div = 16'd4;
    parity_en = 1'b0;
    push(8'hF0);
    tick(50);
    chk("basic_pops", pop_at.size() - base, 1);
    frame_chk("basic_frame", pop_cycle(base), 4, 10, 11'({1'b1, 8'hF0, 1'b0}));
    chk("basic_busy_len", busy_len(pop_cycle(base)), 41);

    base = pop_at.size();
    baud_div = 16'd2;
    parity_en = 1'b1;
    parity_odd = 1'b0;
    push(8'hA5);
    tick(30);
    frame_chk("parity_even", pop_cycle(base), 2, 11, {1'b1, 1'b0, 8'hA5, 1'b0});
    chk("parity_even_busy_len", busy_len(pop_cycle(base)), 23);
    parity_odd = 1'b1;
    push(8'hA5);
    tick(30);
    frame_chk("parity_odd", pop_cycle(base + 1), 2, 11, {1'b1, 1'b1, 8'hA5, 1'b0});

    base = pop_at.size();
    baud_div = 16'd3;
    parity_en = 1'b0;
    push(8'h0F);
    push(8'h55);
    tick(70);
    chk("b2b_pops", pop_at.size() - base, 2);
    chk("b2b_gap", pop_cycle(base + 1) - pop_cycle(base), 30);
    frame_chk("b2b_frame1", pop_cycle(base), 3, 10, 11'({1'b1, 8'h0F, 1'b0}));
    frame_chk("b2b_frame2", pop_cycle(base + 1), 3, 10, 11'({1'b1, 8'h55, 1'b0}));
    chk("b2b_busy_len", busy_len(pop_cycle(base)), 61);

    base = pop_at.size();
    baud_div = 16'd0;
    push(8'h81);
    tick(1);
    baud_div = 16'd8;
    push(8'h3C);
    tick(100);
    chk("div0_gap", pop_cycle(base + 1) - pop_cycle(base), 10);
    frame_chk("div0_frame", pop_cycle(base), 1, 10, 11'({1'b1, 8'h81, 1'b0}));
    frame_chk("div8_frame", pop_cycle(base + 1), 8, 10, 11'({1'b1, 8'h3C, 1'b0}));

    base = pop_at.size();
    baud_div = 16'd4;
    push(8'h5A);
    tick(18);
    chk("midframe_busy", int'(tx_busy), 1);
    n_rst = 1'b0;
    #1;
    chk("async_reset_tx", int'(tx_out), 1);
    chk("async_reset_busy", int'(tx_busy), 0);
    tick(3);
    n_rst = 1'b1;
    tick(20);
    chk("reset_no_refetch", pop_at.size() - base, 1);
    chk("reset_line_idle", int'(tx_out), 1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0 && fifo_q.size() < 4) push(8'($urandom));
      if ($urandom_range(0, 29) == 0) begin
        baud_div = 16'($urandom_range(0, 5));
        parity_en = 1'($urandom);
        parity_odd = 1'($urandom);
      end
      tick(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
